// File: rtl/pwm_pkg.sv
// Shared widths and constants for the PWM output peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
  localparam int unsigned NUM_PINS = 16;

endpackage : pwm_pkg

// File: rtl/pwm_peripheral_if.sv
// Configuration register bundle handed from the SPI register stage to the PWM peripheral.
interface pwm_peripheral_if;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8,
    output en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0, en_reg_out_15_8,
    input en_reg_pwm_7_0, en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface : pwm_peripheral_if

// File: rtl/pwm_prescaler.sv
// Divides clk by CLK_DIV; tick_o is high for the last clk of every CLK_DIV-cycle window.
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : pwm_prescaler

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin forced low, forced high or driven by a shared 8-bit PWM.
// Build option PWM_SHADOW_EN: duty is shadowed and only reloaded at the period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_peripheral_if.slave     cfg,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);

  logic                 tick;
  logic                 wrap;
  logic                 pwm_raw;
  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_CNT_W-1:0] duty;
  logic [NUM_PINS-1:0]  en_out, en_pwm;
  logic [NUM_PINS-1:0]  out_q, out_d;
  logic                 period_start_q;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  assign wrap = tick && (pwm_cnt_q == '1);

`ifdef PWM_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_q;

  // Reload exactly when the count rolls over, so a mid-period write never cuts a pulse short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    duty_q <= '0;
    else if (wrap) duty_q <= cfg.pwm_duty_cycle;
  end

  assign duty = duty_q;
`else
  assign duty = cfg.pwm_duty_cycle;
`endif

  assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

  // Full-scale duty is a true 100 %, not 255/256.
  assign pwm_raw = (duty == PWM_DUTY_FULL) || (pwm_cnt_q < duty);

  always_comb begin
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    out_d     = en_out & (~en_pwm | {NUM_PINS{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      period_start_q <= wrap;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule : pwm_peripheral

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: randomized register writes against a cycle-count reference model.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;
`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] out;
  logic        period_start;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  int tests = 0;
  int fails = 0;

  // Reference model state: n = clk edges since reset release, sh = shadowed duty.
  int       n;
  logic [7:0] sh;
  int       high0;
  int       ps_cnt;
  int       first_ps;

  pwm_peripheral_if cfg_if ();

  assign cfg_if.en_reg_out_7_0  = en_out[7:0];
  assign cfg_if.en_reg_out_15_8 = en_out[15:8];
  assign cfg_if.en_reg_pwm_7_0  = en_pwm[7:0];
  assign cfg_if.en_reg_pwm_15_8 = en_pwm[15:8];
  assign cfg_if.pwm_duty_cycle  = duty;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if),
    .out         (out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clk edge: predict out/period_start from the count position and current registers, then compare.
  task automatic step();
    logic [7:0]  cnt_prev;
    logic [7:0]  d_used;
    logic        raw;
    logic [15:0] exp_out;
    logic        exp_ps;
    @(posedge clk);
    cnt_prev = 8'((n / CLK_DIV) % 256);
    d_used   = SHADOW ? sh : duty;
    raw      = (d_used == 8'hFF) || (cnt_prev < d_used);
    exp_out  = 16'h0000;
    for (int i = 0; i < 16; i++)
      if (en_out[i]) exp_out[i] = en_pwm[i] ? raw : 1'b1;
    exp_ps = ((n + 1) % PERIOD) == 0;
    if (SHADOW && exp_ps) sh = duty;
    n++;
    #1;
    check("out", 32'(out), 32'(exp_out));
    check("period_start", 32'(period_start), 32'(exp_ps));
    if (out[0]) high0++;
    if (period_start) begin
      ps_cnt++;
      if (first_ps < 0) first_ps = n;
    end
  endtask

  task automatic align();
    while (n % PERIOD != 0) step();
  endtask

  // Guarantees the current duty has passed through a wrap before the next period begins.
  task automatic align_load();
    step();
    align();
  endtask

  task automatic measure_period();
    high0 = 0;
    repeat (PERIOD) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en_out = '0; en_pwm = '0; duty = '0;
    rst_n = 1'b0;
    n = 0; sh = '0; high0 = 0; ps_cnt = 0; first_ps = -1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_ps", 32'(period_start), 32'h0);
    rst_n = 1'b1;

    // 1: all registers zero for two periods
    repeat (2 * PERIOD) step();
    check("t1_ps_count", 32'(ps_cnt), 32'd2);

    // 2: all pins forced high, duty irrelevant
    en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'($urandom);
    step();
    check("t2_forced_high", 32'(out), 32'h0000FFFF);
    repeat (40) begin
      duty = 8'($urandom);
      step();
    end

    // 3: pin 0 PWM at 50 %
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    align_load();
    measure_period();
    check("t3_high_80", 32'(high0), 32'd1664);

    // 4: duty extremes, full scale held across consecutive wraps
    duty = 8'h00;
    align_load();
    measure_period();
    check("t4_high_00", 32'(high0), 32'd0);
    duty = 8'hFF;
    align_load();
    measure_period();
    check("t4_high_ff_a", 32'(high0), 32'(PERIOD));
    measure_period();
    check("t4_high_ff_b", 32'(high0), 32'(PERIOD));

    // 5: mid-period duty change at count 100
    duty = 8'h40;
    align_load();
    high0 = 0;
    while (n % PERIOD != 100 * CLK_DIV) step();
    duty = 8'hC0;
    align();
    check("t5_high_cur", 32'(high0), SHADOW ? 32'd832 : 32'd2028);
    measure_period();
    check("t5_high_next", 32'(high0), 32'd2496);

    // 6: randomized register traffic
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
        duty   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      end
      step();
    end

    // 7: asynchronous reset mid-period at count 50
    en_out = 16'hFFFF; en_pwm = 16'h0000;
    while ((n / CLK_DIV) % 256 != 50) step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_out", 32'(out), 32'h0);
    check("t7_async_ps", 32'(period_start), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("t7_hold_out", 32'(out), 32'h0);
    #3 rst_n = 1'b1;
    n = 0; sh = '0; ps_cnt = 0; first_ps = -1;
    en_pwm = 16'($urandom); duty = 8'($urandom);
    repeat (PERIOD + 5) step();
    check("t7_first_ps", 32'(first_ps), 32'(PERIOD));
    check("t7_ps_count", 32'(ps_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pwm_peripheral
